// File: rtl/nibble_sync_ram.sv
// nibble_sync_ram: single-port synchronous RAM with registered read data.
// One write or read per cycle. The read has one cycle of latency.
// Optional feature macro RAM_CLEAR_EN adds a clear engine. After every reset
// it writes zero to each word, one word per cycle. It holds busy high while
// it runs, and all accesses are dropped during that time. When the macro is
// undefined, busy is tied low. Reset then leaves the array contents untouched.
module nibble_sync_ram #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  notChipEnable,
   input  logic                  notWriteEnable,
   input  logic [DATA_WIDTH-1:0] dataIn,
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic                  dataValid,
   output logic                  busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_access;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_clear_we;
   logic [ADDR_WIDTH-1:0] w_clear_addr;
   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [DATA_WIDTH-1:0] w_mem_data;

`ifdef RAM_CLEAR_EN
   localparam logic [ADDR_WIDTH-1:0] C_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] C_LAST = {ADDR_WIDTH{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_clear_addr;

   // Clear engine: reset (re)starts a sweep from word 0. The final word returns to IDLE without wrapping the counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_CLEAR;
         r_clear_addr <= {ADDR_WIDTH{1'b0}};
      end else begin
         case (r_state)
            ST_CLEAR: begin
               if (r_clear_addr == C_LAST) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_clear_addr <= r_clear_addr + C_ONE;
               end
            end
            ST_IDLE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state      <= ST_CLEAR;
               r_clear_addr <= {ADDR_WIDTH{1'b0}};
            end
         endcase
      end
   end

   assign busy         = (r_state == ST_CLEAR);
   assign w_clear_we   = busy & ~reset;
   assign w_clear_addr = r_clear_addr;
`else
   assign busy         = 1'b0;
   assign w_clear_we   = 1'b0;
   assign w_clear_addr = {ADDR_WIDTH{1'b0}};
`endif

   // Decode the user access. The clear engine (if present) has priority over user accesses and reset blocks everything.
   always_comb begin
      w_access   = ~busy & ~notChipEnable & ~reset;
      w_wr       = w_access & ~notWriteEnable;
      w_rd       = w_access & notWriteEnable;
      w_mem_we   = 1'b0;
      w_mem_addr = address;
      w_mem_data = dataIn;
      if (w_clear_we) begin
         w_mem_we   = 1'b1;
         w_mem_addr = w_clear_addr;
         w_mem_data = {DATA_WIDTH{1'b0}};
      end else if (w_wr) begin
         w_mem_we   = 1'b1;
         w_mem_addr = address;
         w_mem_data = dataIn;
      end else begin
         w_mem_we   = 1'b0;
      end
   end

   // Array write port. There is no reset here, so contents survive reset unless the clear engine runs.
   always_ff @(posedge clock) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_data;
      end
   end

   // Registered read data. dataOut keeps its value unless a read is accepted, and dataValid pulses once per accepted read.
   always_ff @(posedge clock) begin
      if (reset) begin
         dataOut   <= {DATA_WIDTH{1'b0}};
         dataValid <= 1'b0;
      end else begin
         dataValid <= w_rd;
         if (w_rd) begin
            dataOut <= r_mem[address];
         end
      end
   end

endmodule

// File: tb/tb_nibble_sync_ram.sv
// Self-checking bench for nibble_sync_ram (DATA_WIDTH=4, ADDR_WIDTH=12).
// Follows the RAM_CLEAR_EN macro so it checks whichever build is compiled.
module tb_nibble_sync_ram;

   localparam int DW    = 4;
   localparam int AW    = 12;
   localparam int DEPTH = 4096;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] address;
   logic          notChipEnable;
   logic          notWriteEnable;
   logic [DW-1:0] dataIn;
   logic [DW-1:0] dataOut;
   logic          dataValid;
   logic          busy;

   int checks = 0;
   int errors = 0;

   // Reference model: the array as plain storage plus a countdown of the words still to clear.
   logic [DW-1:0] ref_mem   [DEPTH];
   bit            ref_known [DEPTH];
   logic [DW-1:0] m_dout;
   bit            m_dout_known = 1'b0;
   bit            m_valid = 1'b0;
   int            m_clear_left = 0;

   nibble_sync_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock          (clock),
      .reset          (reset),
      .address        (address),
      .notChipEnable  (notChipEnable),
      .notWriteEnable (notWriteEnable),
      .dataIn         (dataIn),
      .dataOut        (dataOut),
      .dataValid      (dataValid),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   function automatic bit m_busy();
      return (m_clear_left > 0);
   endfunction

   // Drive one cycle, advance the model by the same edge, and return 1 ns after that edge.
   task automatic step(input bit rst, input logic [AW-1:0] a, input bit nce,
                       input bit nwe, input logic [DW-1:0] d);
      reset          = rst;
      address        = a;
      notChipEnable  = nce;
      notWriteEnable = nwe;
      dataIn         = d;
      if (rst) begin
         m_dout       = 4'b0000;
         m_dout_known = 1'b1;
         m_valid      = 1'b0;
`ifdef RAM_CLEAR_EN
         m_clear_left = DEPTH;
`endif
      end else begin
         m_valid = 1'b0;
         if (m_clear_left > 0) begin
            ref_mem[DEPTH - m_clear_left]   = 4'b0000;
            ref_known[DEPTH - m_clear_left] = 1'b1;
            m_clear_left--;
         end else if (!nce) begin
            if (!nwe) begin
               ref_mem[a]   = d;
               ref_known[a] = 1'b1;
            end else begin
               m_dout       = ref_mem[a];
               m_dout_known = ref_known[a];
               m_valid      = 1'b1;
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 12'h000, 1'b1, 1'b1, 4'h0);
   endtask

   // Wait for busy to fall and return how many samples showed it high, giving up after a fixed cycle budget.
   task automatic count_busy(output int cnt, input bit poke);
      cnt = 0;
      while (busy === 1'b1 && cnt < DEPTH + 100) begin
         cnt++;
         if (poke && cnt == 100) step(1'b0, 12'h005, 1'b0, 1'b0, 4'b1111);
         else idle();
      end
   endtask

   task automatic test_reset();
      step(1'b1, 12'h000, 1'b1, 1'b1, 4'h0);
      step(1'b1, 12'h000, 1'b1, 1'b1, 4'h0);
      checks++;
      if (dataOut !== 4'b0000) begin errors++; $display("FAIL reset_dout got=%b exp=0000", dataOut); end
      checks++;
      if (dataValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dataValid); end
      checks++;
      if (busy !== m_busy()) begin errors++; $display("FAIL reset_busy got=%b exp=%b", busy, m_busy()); end
   endtask

`ifdef RAM_CLEAR_EN
   task automatic test_clear();
      int cnt;
      count_busy(cnt, 1'b1);
      checks++;
      if (cnt !== DEPTH) begin errors++; $display("FAIL clear_busy_cycles got=%0d exp=%0d", cnt, DEPTH); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy_low got=%b exp=0", busy); end
      step(1'b0, 12'h000, 1'b0, 1'b1, 4'h0);
      checks++;
      if (dataValid !== 1'b1 || dataOut !== 4'b0000) begin
         errors++; $display("FAIL clear_rd000 got=%b/%b exp=1/0000", dataValid, dataOut);
      end
      step(1'b0, 12'hF7B, 1'b0, 1'b1, 4'h0);
      checks++;
      if (dataValid !== 1'b1 || dataOut !== 4'b0000) begin
         errors++; $display("FAIL clear_rdF7B got=%b/%b exp=1/0000", dataValid, dataOut);
      end
      step(1'b0, 12'h005, 1'b0, 1'b1, 4'h0);
      checks++;
      if (dataValid !== 1'b1 || dataOut !== 4'b0000) begin
         errors++; $display("FAIL busy_write_dropped got=%b/%b exp=1/0000", dataValid, dataOut);
      end
   endtask

   task automatic test_reset_mid_clear();
      int cnt;
      step(1'b1, 12'h000, 1'b1, 1'b1, 4'h0);
      for (int i = 0; i < 2000; i++) idle();
      step(1'b1, 12'h000, 1'b1, 1'b1, 4'h0);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL midclear_busy got=%b exp=1", busy); end
      count_busy(cnt, 1'b0);
      checks++;
      if (cnt !== DEPTH) begin errors++; $display("FAIL midclear_cycles got=%0d exp=%0d", cnt, DEPTH); end
   endtask
`else
   task automatic test_reset_keeps_data();
      step(1'b0, 12'h001, 1'b0, 1'b0, 4'b1100);
      checks++;
      if (busy !== 1'b0 || dataValid !== 1'b0) begin
         errors++; $display("FAIL nc_write busy/valid got=%b/%b exp=0/0", busy, dataValid);
      end
      step(1'b1, 12'h000, 1'b1, 1'b1, 4'h0);
      checks++;
      if (busy !== 1'b0 || dataOut !== 4'b0000) begin
         errors++; $display("FAIL nc_reset busy/dout got=%b/%b exp=0/0000", busy, dataOut);
      end
      step(1'b0, 12'h001, 1'b0, 1'b1, 4'h0);
      checks++;
      if (dataValid !== 1'b1 || dataOut !== 4'b1100 || busy !== 1'b0) begin
         errors++; $display("FAIL nc_keep got=%b/%b/%b exp=1/1100/0", dataValid, dataOut, busy);
      end
   endtask
`endif

   task automatic test_pattern();
      logic [AW-1:0] a [4];
      logic [DW-1:0] d [4];
      a = '{12'h000, 12'h001, 12'h002, 12'hF7B};
      d = '{4'b0011, 4'b1100, 4'b0110, 4'b1001};
      for (int i = 0; i < 4; i++) begin
         step(1'b0, a[i], 1'b0, 1'b0, d[i]);
         checks++;
         if (dataValid !== 1'b0) begin errors++; $display("FAIL wr_valid[%0d] got=%b exp=0", i, dataValid); end
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, a[i], 1'b0, 1'b1, 4'h0);
         checks++;
         if (dataValid !== 1'b1 || dataOut !== d[i]) begin
            errors++; $display("FAIL b2b_rd[%0d] got=%b/%b exp=1/%b", i, dataValid, dataOut, d[i]);
         end
      end
      step(1'b0, 12'h010, 1'b0, 1'b0, 4'b0101);
      step(1'b0, 12'h010, 1'b0, 1'b1, 4'h0);
      checks++;
      if (dataValid !== 1'b1 || dataOut !== 4'b0101) begin
         errors++; $display("FAIL wr_then_rd got=%b/%b exp=1/0101", dataValid, dataOut);
      end
   endtask

   task automatic test_chip_disable();
      logic [DW-1:0] held;
      held = m_dout;
      step(1'b0, 12'h000, 1'b1, 1'b0, 4'b0011);
      step(1'b0, 12'h001, 1'b1, 1'b0, 4'b1100);
      step(1'b0, 12'h000, 1'b1, 1'b0, 4'b1111);
      step(1'b0, 12'hF7B, 1'b1, 1'b1, 4'h0);
      step(1'b0, 12'h000, 1'b1, 1'b1, 4'h0);
      checks++;
      if (dataValid !== 1'b0 || dataOut !== held) begin
         errors++; $display("FAIL nce_hold got=%b/%b exp=0/%b", dataValid, dataOut, held);
      end
      step(1'b0, 12'h000, 1'b0, 1'b1, 4'h0);
      checks++;
      if (dataOut !== ref_mem[12'h000] || dataValid !== 1'b1) begin
         errors++; $display("FAIL nce_no_write got=%b/%b exp=1/%b", dataValid, dataOut, ref_mem[12'h000]);
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      int            op;
      bit            nce;
      bit            nwe;
      for (int i = 0; i < 400; i++) begin
         op  = int'($urandom_range(0, 3));
         a   = ($urandom_range(0, 3) == 0) ? AW'(12'hF70 + $urandom_range(0, 15)) : AW'($urandom_range(0, 31));
         nce = (op == 2);
         nwe = (op != 0);
         if (!nce && nwe && !ref_known[a]) nwe = 1'b0;
         step(1'b0, a, nce, nwe, DW'($urandom_range(0, 15)));
         checks++;
         if (dataValid !== m_valid || busy !== m_busy()) begin
            errors++; $display("FAIL rand_ctl[%0d] got=%b/%b exp=%b/%b", i, dataValid, busy, m_valid, m_busy());
         end
         if (m_dout_known) begin
            checks++;
            if (dataOut !== m_dout) begin
               errors++; $display("FAIL rand_dout[%0d] got=%b exp=%b", i, dataOut, m_dout);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; address = '0; notChipEnable = 1'b1; notWriteEnable = 1'b1; dataIn = '0;
      for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
      test_reset();
`ifdef RAM_CLEAR_EN
      test_clear();
`else
      test_reset_keeps_data();
`endif
      test_pattern();
      test_chip_disable();
      test_random();
`ifdef RAM_CLEAR_EN
      test_reset_mid_clear();
      test_random();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
